// File: rtl/fsm_quicksort_pkg.sv
// Shared types for the quicksort engine: bank lifecycle, bank context and index widths.
package fsm_quicksort_pkg;

  localparam int unsigned N      = 16;
  localparam int unsigned BANK_N = 2;

  // Wide enough to carry an over-range enqueue count (N+1 or more) for error detection.
  localparam int unsigned NW     = $clog2(N + 2);
  localparam int unsigned BankW  = (BANK_N > 1) ? $clog2(BANK_N) : 1;

  typedef logic [NW-1:0]    n_t;
  typedef logic [BankW-1:0] bank_n_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoading,
    StReady,
    StSorting,
    StSorted,
    StUnloading
  } bank_status_t;

  typedef struct packed {
    bank_status_t status;
    n_t           n;
    logic         error;
  } bank_state_t;

endpackage

// File: rtl/fsm_quicksort_bank_ctxt.sv
// One sort bank's lifecycle register: status, entry count and error flag.
module fsm_quicksort_bank_ctxt
  import fsm_quicksort_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_start_i,
  input  logic        load_done_i,
  input  n_t          load_n_i,
  input  logic        sort_start_i,
  input  logic        sort_done_i,
  input  logic        sort_error_i,
  input  logic        unload_start_i,
  input  logic        unload_done_i,
  output bank_state_t state_o
);

  bank_state_t state_q;

  // Bank lifecycle FSM; each strobe only acts in the status it belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '{status: StIdle, n: '0, error: 1'b0};
    end else begin
      unique case (state_q.status)
        StIdle: begin
          if (load_start_i) state_q.status <= StLoading;
        end
        StLoading: begin
          if (load_done_i) begin
            if (load_n_i == '0) begin
              // Empty batch: nothing to sort, hand straight to dequeue.
              state_q <= '{status: StSorted, n: '0, error: 1'b0};
            end else if (load_n_i > n_t'(N)) begin
              state_q <= '{status: StSorted, n: '0, error: 1'b1};
            end else begin
              state_q <= '{status: StReady, n: load_n_i, error: 1'b0};
            end
          end
        end
        StReady: begin
          if (sort_start_i) state_q.status <= StSorting;
        end
        StSorting: begin
          if (sort_done_i) begin
            state_q.status <= StSorted;
            state_q.error  <= state_q.error | sort_error_i;
          end
        end
        StSorted: begin
          if (unload_start_i) state_q.status <= StUnloading;
        end
        StUnloading: begin
          if (unload_done_i) state_q <= '{status: StIdle, n: '0, error: 1'b0};
        end
        default: state_q <= '{status: StIdle, n: '0, error: 1'b0};
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/fsm_quicksort_bank_sched.sv
// In-order bank scheduler between the enqueue, sort and dequeue FSMs.
module fsm_quicksort_bank_sched
  import fsm_quicksort_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enq_vld_i,
  output logic                     enq_rdy_o,
  output bank_n_t                  enq_bank_o,
  input  logic                     enq_done_i,
  input  n_t                       enq_n_i,
  output logic                     sort_vld_o,
  input  logic                     sort_rdy_i,
  output bank_n_t                  sort_bank_o,
  output n_t                       sort_n_o,
  input  logic                     sort_done_i,
  input  logic                     sort_error_i,
  output logic                     deq_vld_o,
  input  logic                     deq_rdy_i,
  output bank_n_t                  deq_bank_o,
  output n_t                       deq_n_o,
  output logic                     deq_error_o,
  input  logic                     deq_done_i,
  output bank_state_t [BANK_N-1:0] bank_state_o,
  output logic                     busy_o,
  output logic                     protocol_err_o
);

  localparam int unsigned CntW = $clog2(BANK_N + 1);
  typedef logic [CntW-1:0] cnt_t;

  function automatic bank_n_t ptr_inc(bank_n_t p);
    return (p == bank_n_t'(BANK_N - 1)) ? '0 : bank_n_t'(p + 1'b1);
  endfunction

  bank_n_t wr_ptr_q, wr_ptr_d, srt_ptr_q, srt_ptr_d, rd_ptr_q, rd_ptr_d;
  // Banks the sort pointer has passed that are not yet unloaded; disambiguates
  // srt_ptr == rd_ptr between "sort caught up" and "sort lapped the reader".
  cnt_t    sorted_cnt_q, sorted_cnt_d;
  logic    protocol_err_q, protocol_err_d;

  bank_state_t wr_bank, srt_bank, rd_bank;
  logic enq_fire, sort_fire, deq_fire;
  logic enq_done_ok, sort_done_ok, deq_done_ok, srt_skip, srt_adv;
  logic [BANK_N-1:0] load_start, load_done, sort_start, sort_done, unload_start, unload_done;

  assign wr_bank  = bank_state_o[wr_ptr_q];
  assign srt_bank = bank_state_o[srt_ptr_q];
  assign rd_bank  = bank_state_o[rd_ptr_q];

  assign enq_rdy_o   = (wr_bank.status == StIdle);
  assign enq_bank_o  = wr_ptr_q;
  assign sort_vld_o  = (srt_bank.status == StReady);
  assign sort_bank_o = srt_ptr_q;
  assign sort_n_o    = srt_bank.n;
  assign deq_vld_o   = (rd_bank.status == StSorted);
  assign deq_bank_o  = rd_ptr_q;
  assign deq_n_o     = rd_bank.n;
  assign deq_error_o = rd_bank.error;
  assign protocol_err_o = protocol_err_q;

  assign enq_fire  = enq_vld_i & enq_rdy_o;
  assign sort_fire = sort_vld_o & sort_rdy_i;
  assign deq_fire  = deq_vld_o & deq_rdy_i;

  assign enq_done_ok  = enq_done_i & (wr_bank.status == StLoading);
  assign sort_done_ok = sort_done_i & (srt_bank.status == StSorting);
  assign deq_done_ok  = deq_done_i & (rd_bank.status == StUnloading);
  // A SORTED bank under srt_ptr was sent there by enqueue unless sort has lapped the reader.
  assign srt_skip     = (srt_bank.status == StSorted) & (sorted_cnt_q != cnt_t'(BANK_N));
  assign srt_adv      = sort_done_ok | srt_skip;

  // Route each stage's strobes to the bank its pointer selects.
  always_comb begin
    load_start   = '0;
    load_done    = '0;
    sort_start   = '0;
    sort_done    = '0;
    unload_start = '0;
    unload_done  = '0;
    for (int b = 0; b < BANK_N; b++) begin
      load_start[b]   = enq_fire & (wr_ptr_q == bank_n_t'(b));
      load_done[b]    = enq_done_ok & (wr_ptr_q == bank_n_t'(b));
      sort_start[b]   = sort_fire & (srt_ptr_q == bank_n_t'(b));
      sort_done[b]    = sort_done_ok & (srt_ptr_q == bank_n_t'(b));
      unload_start[b] = deq_fire & (rd_ptr_q == bank_n_t'(b));
      unload_done[b]  = deq_done_ok & (rd_ptr_q == bank_n_t'(b));
    end
  end

  // Pointer, in-flight count and sticky protocol error next state.
  always_comb begin
    wr_ptr_d     = enq_done_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    srt_ptr_d    = srt_adv ? ptr_inc(srt_ptr_q) : srt_ptr_q;
    rd_ptr_d     = deq_done_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    sorted_cnt_d = sorted_cnt_q;
    if (srt_adv && !deq_done_ok) begin
      sorted_cnt_d = sorted_cnt_q + cnt_t'(1);
    end else if (!srt_adv && deq_done_ok) begin
      sorted_cnt_d = sorted_cnt_q - cnt_t'(1);
    end
    protocol_err_d = protocol_err_q
                   | (enq_done_i & ~enq_done_ok)
                   | (sort_done_i & ~sort_done_ok)
                   | (deq_done_i & ~deq_done_ok);
  end

  // Scheduler state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q       <= '0;
      srt_ptr_q      <= '0;
      rd_ptr_q       <= '0;
      sorted_cnt_q   <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      srt_ptr_q      <= srt_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      sorted_cnt_q   <= sorted_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Busy whenever any bank has left IDLE.
  always_comb begin
    busy_o = 1'b0;
    for (int b = 0; b < BANK_N; b++) begin
      busy_o = busy_o | (bank_state_o[b].status != StIdle);
    end
  end

  for (genvar g = 0; g < BANK_N; g++) begin : g_bank
    fsm_quicksort_bank_ctxt u_ctxt (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .load_start_i   (load_start[g]),
      .load_done_i    (load_done[g]),
      .load_n_i       (enq_n_i),
      .sort_start_i   (sort_start[g]),
      .sort_done_i    (sort_done[g]),
      .sort_error_i   (sort_error_i),
      .unload_start_i (unload_start[g]),
      .unload_done_i  (unload_done[g]),
      .state_o        (bank_state_o[g])
    );
  end

endmodule

// File: tb/tb_fsm_quicksort_bank_sched.sv
// Self-checking bench for the quicksort bank scheduler.
module tb_fsm_quicksort_bank_sched;
  import fsm_quicksort_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enq_vld, enq_rdy, enq_done;
  bank_n_t enq_bank;
  n_t enq_n;
  logic sort_vld, sort_rdy, sort_done, sort_error;
  bank_n_t sort_bank;
  n_t sort_n;
  logic deq_vld, deq_rdy, deq_error, deq_done;
  bank_n_t deq_bank;
  n_t deq_n;
  bank_state_t [BANK_N-1:0] bank_state;
  logic busy, protocol_err;

  int n_run = 0;
  int n_fail = 0;

  localparam int SLoad = 1, SReady = 2, SSort = 3, SSorted = 4, SUnload = 5;
  typedef struct {int stage; int bank; int n; bit err;} batch_t;

  fsm_quicksort_bank_sched dut (
    .clk_i(clk), .rst_ni(rst_n),
    .enq_vld_i(enq_vld), .enq_rdy_o(enq_rdy), .enq_bank_o(enq_bank),
    .enq_done_i(enq_done), .enq_n_i(enq_n),
    .sort_vld_o(sort_vld), .sort_rdy_i(sort_rdy), .sort_bank_o(sort_bank),
    .sort_n_o(sort_n), .sort_done_i(sort_done), .sort_error_i(sort_error),
    .deq_vld_o(deq_vld), .deq_rdy_i(deq_rdy), .deq_bank_o(deq_bank),
    .deq_n_o(deq_n), .deq_error_o(deq_error), .deq_done_i(deq_done),
    .bank_state_o(bank_state), .busy_o(busy), .protocol_err_o(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enq_vld = 0; enq_done = 0; enq_n = '0;
    sort_rdy = 0; sort_done = 0; sort_error = 0;
    deq_rdy = 0; deq_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic do_enq(int n);
    enq_vld = 1; cyc(); enq_vld = 0;
    enq_done = 1; enq_n = n_t'(n); cyc(); enq_done = 0; enq_n = '0;
  endtask
  task automatic do_sort_start();
    sort_rdy = 1; cyc(); sort_rdy = 0;
  endtask
  task automatic do_sort_done(bit e);
    sort_done = 1; sort_error = e; cyc(); sort_done = 0; sort_error = 0;
  endtask
  task automatic do_deq_start();
    deq_rdy = 1; cyc(); deq_rdy = 0;
  endtask
  task automatic do_deq_done();
    deq_done = 1; cyc(); deq_done = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_enq_rdy got %0b want 1", enq_rdy); end
    n_run++; if (enq_bank !== '0) begin n_fail++; $display("FAIL reset_enq_bank got %0d want 0", enq_bank); end
    n_run++; if (sort_vld !== 1'b0) begin n_fail++; $display("FAIL reset_sort_vld got %0b want 0", sort_vld); end
    n_run++; if (deq_vld !== 1'b0) begin n_fail++; $display("FAIL reset_deq_vld got %0b want 0", deq_vld); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_run++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %0b want 0", protocol_err); end
    for (int b = 0; b < BANK_N; b++) begin
      n_run++;
      if (bank_state[b] !== '{status: StIdle, n: '0, error: 1'b0}) begin
        n_fail++; $display("FAIL reset_bank%0d got %0h want idle/0/0", b, bank_state[b]);
      end
    end
  endtask

  task automatic test_single_batch();
    do_reset();
    enq_vld = 1; cyc(); enq_vld = 0;
    n_run++; if (bank_state[0].status !== StLoading) begin n_fail++; $display("FAIL single_loading got %0d want %0d", bank_state[0].status, StLoading); end
    n_run++; if (enq_rdy !== 1'b0) begin n_fail++; $display("FAIL single_enq_rdy got %0b want 0", enq_rdy); end
    enq_done = 1; enq_n = n_t'(16); cyc(); enq_done = 0;
    n_run++; if (bank_state[0].status !== StReady) begin n_fail++; $display("FAIL single_ready got %0d want %0d", bank_state[0].status, StReady); end
    n_run++; if (sort_vld !== 1'b1 || sort_bank !== 0 || sort_n !== 16) begin n_fail++; $display("FAIL single_sort_req got vld%0b b%0d n%0d want vld1 b0 n16", sort_vld, sort_bank, sort_n); end
    do_sort_start();
    n_run++; if (bank_state[0].status !== StSorting || sort_vld !== 1'b0) begin n_fail++; $display("FAIL single_sorting got %0d/%0b want %0d/0", bank_state[0].status, sort_vld, StSorting); end
    do_sort_done(0);
    n_run++; if (bank_state[0].status !== StSorted) begin n_fail++; $display("FAIL single_sorted got %0d want %0d", bank_state[0].status, StSorted); end
    n_run++; if (deq_vld !== 1'b1 || deq_bank !== 0 || deq_n !== 16 || deq_error !== 1'b0) begin n_fail++; $display("FAIL single_deq_req got vld%0b b%0d n%0d e%0b want vld1 b0 n16 e0", deq_vld, deq_bank, deq_n, deq_error); end
    do_deq_start();
    n_run++; if (bank_state[0].status !== StUnloading) begin n_fail++; $display("FAIL single_unloading got %0d want %0d", bank_state[0].status, StUnloading); end
    do_deq_done();
    n_run++; if (bank_state[0] !== '{status: StIdle, n: '0, error: 1'b0} || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %0h busy%0b want idle busy0", bank_state[0], busy); end
    n_run++; if (enq_bank !== 1 || sort_bank !== 1 || deq_bank !== 1) begin n_fail++; $display("FAIL single_ptrs got %0d/%0d/%0d want 1/1/1", enq_bank, sort_bank, deq_bank); end
  endtask

  task automatic test_pipelined();
    int got_b[4];
    int got_n[4];
    int exp_b[4] = '{0, 1, 0, 1};
    int exp_n[4] = '{3, 4, 5, 6};
    do_reset();
    do_enq(3); do_sort_start(); do_enq(4);
    n_run++; if (sort_vld !== 1'b0 || sort_bank !== 0) begin n_fail++; $display("FAIL pipe_hold got vld%0b b%0d want vld0 b0", sort_vld, sort_bank); end
    do_sort_done(0);
    n_run++; if (sort_vld !== 1'b1 || sort_bank !== 1) begin n_fail++; $display("FAIL pipe_next got vld%0b b%0d want vld1 b1", sort_vld, sort_bank); end
    got_b[0] = deq_vld ? int'(deq_bank) : -1; got_n[0] = int'(deq_n);
    do_deq_start(); do_sort_start(); do_deq_done();
    do_enq(5); do_sort_done(0); do_sort_start();
    got_b[1] = deq_vld ? int'(deq_bank) : -1; got_n[1] = int'(deq_n);
    do_deq_start(); do_deq_done();
    do_enq(6); do_sort_done(0);
    got_b[2] = deq_vld ? int'(deq_bank) : -1; got_n[2] = int'(deq_n);
    do_deq_start(); do_deq_done();
    do_sort_start(); do_sort_done(0);
    got_b[3] = deq_vld ? int'(deq_bank) : -1; got_n[3] = int'(deq_n);
    do_deq_start(); do_deq_done();
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (got_b[i] != exp_b[i] || got_n[i] != exp_n[i]) begin
        n_fail++; $display("FAIL pipe_order%0d got b%0d n%0d want b%0d n%0d", i, got_b[i], got_n[i], exp_b[i], exp_n[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    do_enq(2); do_sort_start(); do_sort_done(0);
    do_enq(3); do_sort_start(); do_sort_done(0);
    n_run++; if (enq_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_enq_rdy got %0b want 0", enq_rdy); end
    cyc();
    n_run++; if (sort_bank !== 0 || sort_vld !== 1'b0) begin n_fail++; $display("FAIL stall_sort_ptr got b%0d vld%0b want b0 vld0", sort_bank, sort_vld); end
    n_run++; if (deq_vld !== 1'b1 || deq_bank !== 0 || deq_n !== 2) begin n_fail++; $display("FAIL stall_deq got vld%0b b%0d n%0d want vld1 b0 n2", deq_vld, deq_bank, deq_n); end
    do_deq_start(); do_deq_done();
    n_run++; if (enq_rdy !== 1'b1 || enq_bank !== 0) begin n_fail++; $display("FAIL stall_release got rdy%0b b%0d want rdy1 b0", enq_rdy, enq_bank); end
    n_run++; if (deq_vld !== 1'b1 || deq_bank !== 1 || deq_n !== 3) begin n_fail++; $display("FAIL stall_deq2 got vld%0b b%0d n%0d want vld1 b1 n3", deq_vld, deq_bank, deq_n); end
  endtask

  task automatic test_boundary();
    do_reset();
    do_enq(0);
    n_run++; if (sort_vld !== 1'b0) begin n_fail++; $display("FAIL bnd_zero_sort got %0b want 0", sort_vld); end
    n_run++; if (deq_vld !== 1'b1 || deq_bank !== 0 || deq_n !== 0 || deq_error !== 1'b0) begin n_fail++; $display("FAIL bnd_zero_deq got vld%0b b%0d n%0d e%0b want vld1 b0 n0 e0", deq_vld, deq_bank, deq_n, deq_error); end
    cyc();
    n_run++; if (sort_bank !== 1) begin n_fail++; $display("FAIL bnd_zero_skip got %0d want 1", sort_bank); end
    do_deq_start(); do_deq_done();
    do_enq(17);
    n_run++; if (deq_vld !== 1'b1 || deq_bank !== 1 || deq_n !== 0 || deq_error !== 1'b1 || sort_vld !== 1'b0) begin n_fail++; $display("FAIL bnd_over got vld%0b b%0d n%0d e%0b svld%0b want vld1 b1 n0 e1 svld0", deq_vld, deq_bank, deq_n, deq_error, sort_vld); end
    do_deq_start(); do_deq_done();
    do_enq(9); do_sort_start(); do_sort_done(1);
    n_run++; if (deq_vld !== 1'b1 || deq_bank !== 0 || deq_n !== 9 || deq_error !== 1'b1) begin n_fail++; $display("FAIL bnd_sorterr got vld%0b b%0d n%0d e%0b want vld1 b0 n9 e1", deq_vld, deq_bank, deq_n, deq_error); end
    do_deq_start(); do_deq_done();
  endtask

  task automatic test_spurious();
    do_reset();
    do_sort_done(0);
    n_run++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL spur_sort_perr got %0b want 1", protocol_err); end
    n_run++; if (bank_state[0].status !== StIdle || bank_state[1].status !== StIdle || busy !== 1'b0) begin n_fail++; $display("FAIL spur_sort_state got %0d/%0d busy%0b want idle", bank_state[0].status, bank_state[1].status, busy); end
    n_run++; if (sort_bank !== 0) begin n_fail++; $display("FAIL spur_sort_ptr got %0d want 0", sort_bank); end
    do_reset();
    do_enq(5);
    do_deq_done();
    n_run++; if (protocol_err !== 1'b1 || bank_state[0].status !== StReady || deq_bank !== 0) begin n_fail++; $display("FAIL spur_deq got perr%0b st%0d rd%0d want perr1 st%0d rd0", protocol_err, bank_state[0].status, deq_bank, StReady); end
    cyc();
    n_run++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got %0b want 1", protocol_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_enq(4); do_sort_start();
    #2;
    rst_n = 0;
    #1;
    n_run++; if (busy !== 1'b0 || enq_rdy !== 1'b1 || sort_vld !== 1'b0 || deq_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_outs got busy%0b rdy%0b svld%0b dvld%0b want 0 1 0 0", busy, enq_rdy, sort_vld, deq_vld); end
    n_run++; if (bank_state[0].status !== StIdle || bank_state[0].n !== '0 || protocol_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_bank got st%0d n%0d perr%0b want idle n0 perr0", bank_state[0].status, bank_state[0].n, protocol_err); end
    cyc();
    rst_n = 1;
    cyc();
    do_sort_done(0);
    n_run++; if (protocol_err !== 1'b1 || bank_state[0].status !== StIdle) begin n_fail++; $display("FAIL rstmid_late_done got perr%0b st%0d want perr1 idle", protocol_err, bank_state[0].status); end
  endtask

  task automatic test_random();
    batch_t q[$];
    int enq_seq = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit e_rdy, s_vld, d_vld, has_load, has_sort, has_unl;
      int sidx, r;
      e_rdy = 0; s_vld = 0; d_vld = 0; has_load = 0; has_sort = 0; has_unl = 0; sidx = -1;
      foreach (q[i]) begin
        if (q[i].stage == SLoad) has_load = 1;
        if (q[i].stage == SSort) has_sort = 1;
        if (q[i].stage == SUnload) has_unl = 1;
        if (sidx < 0 && (q[i].stage == SLoad || q[i].stage == SReady || q[i].stage == SSort)) sidx = i;
      end
      e_rdy = (q.size() < BANK_N) && !has_load;
      s_vld = (sidx >= 0) && (q[sidx].stage == SReady);
      d_vld = (q.size() > 0) && (q[0].stage == SSorted);

      n_run++; if (enq_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_enq_rdy c%0d got %0b want %0b", c, enq_rdy, e_rdy); end
      n_run++; if (sort_vld !== s_vld) begin n_fail++; $display("FAIL rnd_sort_vld c%0d got %0b want %0b", c, sort_vld, s_vld); end
      n_run++; if (deq_vld !== d_vld) begin n_fail++; $display("FAIL rnd_deq_vld c%0d got %0b want %0b", c, deq_vld, d_vld); end
      n_run++; if (busy !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d got %0b want %0b", c, busy, q.size() != 0); end
      if (e_rdy) begin
        n_run++; if (int'(enq_bank) != enq_seq % BANK_N) begin n_fail++; $display("FAIL rnd_enq_bank c%0d got %0d want %0d", c, enq_bank, enq_seq % BANK_N); end
      end
      if (s_vld) begin
        n_run++; if (int'(sort_bank) != q[sidx].bank || int'(sort_n) != q[sidx].n) begin n_fail++; $display("FAIL rnd_sort_sel c%0d got b%0d n%0d want b%0d n%0d", c, sort_bank, sort_n, q[sidx].bank, q[sidx].n); end
      end
      if (d_vld) begin
        n_run++; if (int'(deq_bank) != q[0].bank || int'(deq_n) != q[0].n || deq_error !== q[0].err) begin n_fail++; $display("FAIL rnd_deq_sel c%0d got b%0d n%0d e%0b want b%0d n%0d e%0b", c, deq_bank, deq_n, deq_error, q[0].bank, q[0].n, q[0].err); end
      end

      enq_vld = 1'($urandom_range(0, 1));
      enq_done = has_load && ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 9));
      enq_n = (r == 0) ? n_t'(0) : (r == 1) ? n_t'($urandom_range(17, 31)) : n_t'($urandom_range(1, 16));
      sort_rdy = 1'($urandom_range(0, 1));
      sort_done = has_sort && ($urandom_range(0, 2) == 0);
      sort_error = ($urandom_range(0, 3) == 0);
      deq_rdy = 1'($urandom_range(0, 1));
      deq_done = has_unl && ($urandom_range(0, 2) == 0);
      cyc();

      foreach (q[i]) begin
        if (enq_done && q[i].stage == SLoad) begin
          if (enq_n == 0) begin q[i].stage = SSorted; q[i].n = 0; q[i].err = 0; end
          else if (int'(enq_n) > N) begin q[i].stage = SSorted; q[i].n = 0; q[i].err = 1; end
          else begin q[i].stage = SReady; q[i].n = int'(enq_n); q[i].err = 0; end
        end else if (sort_done && q[i].stage == SSort) begin
          q[i].stage = SSorted; q[i].err = q[i].err | sort_error;
        end
      end
      if (s_vld && sort_rdy) q[sidx].stage = SSort;
      if (deq_done && q[0].stage == SUnload) void'(q.pop_front());
      else if (d_vld && deq_rdy) q[0].stage = SUnload;
      if (e_rdy && enq_vld) begin
        q.push_back('{stage: SLoad, bank: enq_seq % BANK_N, n: 0, err: 0});
        enq_seq++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_batch();
    test_pipelined();
    test_full_stall();
    test_boundary();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
